// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative RV32M multiply/divide.
// Latency 1 (single-cycle) or XLEN+1 (mul/div); holds result under out_ready=0.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ctrl,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] CNT0 = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT1 = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [SHW:0]      cnt;
  logic [4:0]        op;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   opb, res, fin, mag_a, mag_b, quo, rem;
  logic [XLEN:0]     rsh, diff, psum;
  logic              neg_q, neg_r, is_iter, a_signed, b_signed, sa, sb;
  logic [SHW-1:0]    sh;

  assign in_ready = ~kill & ((state == IDLE) | ((state == DONE) & out_ready));
  assign is_iter  = (ctrl[4:3] == 2'b10);
  assign sh       = data2[SHW-1:0];

  assign a_signed = (ctrl == 5'd17) | (ctrl == 5'd18) | (ctrl == 5'd20) | (ctrl == 5'd22);
  assign b_signed = (ctrl == 5'd17) | (ctrl == 5'd20) | (ctrl == 5'd22);
  assign sa       = a_signed & data1[XLEN-1];
  assign sb       = b_signed & data2[XLEN-1];
  assign mag_a    = sa ? -data1 : data1;
  assign mag_b    = sb ? -data2 : data2;

  always_comb begin
    res = '0;
    case (ctrl)
      5'd0:  res = data1 & data2;
      5'd1:  res = data1 | data2;
      5'd2:  res = data1 + data2;
      5'd3:  res = data1 - data2;
      5'd4:  res = data1 ^ data2;
      5'd5:  res = {{(XLEN-1){1'b0}}, data1 == data2};
      5'd6:  res = {{(XLEN-1){1'b0}}, data1 != data2};
      5'd7:  res = {{(XLEN-1){1'b0}}, $signed(data1) <  $signed(data2)};
      5'd8:  res = {{(XLEN-1){1'b0}}, $signed(data1) >= $signed(data2)};
      5'd9:  res = {{(XLEN-1){1'b0}}, data1 <  data2};
      5'd10: res = {{(XLEN-1){1'b0}}, data1 >= data2};
      5'd11: res = data1 << sh;
      5'd12: res = data1 >> sh;
      5'd13: res = XLEN'($signed(data1) >>> sh);
      default: res = '0;
    endcase
  end

  // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps {partial, multiplier}.
  always_comb begin
    rsh     = acc[2*XLEN-1:XLEN-1];
    diff    = rsh - {1'b0, opb};
    psum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    acc_nxt = acc;
    if (op[2]) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {rsh[XLEN-1:0],  acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {psum, acc[XLEN-1:1]};
    end
  end

  // Signed overflow falls out of the magnitude arithmetic; only divide-by-zero quotient is forced.
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    fin  = '0;
    case (op)
      5'd16:                      fin = prod[XLEN-1:0];
      5'd17, 5'd18, 5'd19:        fin = prod[2*XLEN-1:XLEN];
      5'd20, 5'd21:               fin = (opb == '0) ? '1 : quo;
      5'd22, 5'd23:               fin = rem;
      default:                    fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (kill) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT1;
          if (cnt == CNT1) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out       <= fin;
          end
        end
        default: begin
          if (state == IDLE || out_ready) begin
            if (in_valid) begin
              op <= ctrl;
              if (is_iter) begin
                state     <= BUSY;
                busy      <= 1'b1;
                out_valid <= 1'b0;
                cnt       <= CNT0;
                neg_q     <= sa ^ sb;
                neg_r     <= sa;
                if (ctrl[2]) begin
                  acc <= {{XLEN{1'b0}}, mag_a};
                  opb <= mag_b;
                end else begin
                  acc <= {{XLEN{1'b0}}, mag_b};
                  opb <= mag_a;
                end
              end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                out       <= res;
              end
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed table-driven bench for alu_mc plus backpressure, kill and reset sequences.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  ctrl = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] dout;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .data1(data1), .data2(data2), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  vec_t vec [30];
  int   nvec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic run_op(input string nm, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
    int n;
    int bc;
    logic rdy_seen;
    ctrl = c; data1 = a; data2 = b; in_valid = 1'b1;
    #1;
    chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1; bc = 0; rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (busy) bc++;
      if (in_ready) rdy_seen = 1'b1;
      ctrl = 5'd2; data1 = 32'h1234; data2 = 32'h1; in_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({nm, " out"}, dout, e);
    chk({nm, " latency"}, n, lat);
    if (lat > 1) begin
      chk({nm, " busy cycles"}, bc, 32);
      chk({nm, " in_ready while busy"}, {31'b0, rdy_seen}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    nvec = 0;
    vec[nvec++] = '{5'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vec[nvec++] = '{5'd13, 32'h80000000, 32'h00000004, 32'hF8000000, 1};
    vec[nvec++] = '{5'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vec[nvec++] = '{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vec[nvec++] = '{5'd11, 32'h00000001, 32'h00000023, 32'h00000008, 1};
    vec[nvec++] = '{5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1};
    vec[nvec++] = '{5'd1,  32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1};
    vec[nvec++] = '{5'd4,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1};
    vec[nvec++] = '{5'd3,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1};
    vec[nvec++] = '{5'd5,  32'h00000003, 32'h00000003, 32'h00000001, 1};
    vec[nvec++] = '{5'd6,  32'h00000003, 32'h00000003, 32'h00000000, 1};
    vec[nvec++] = '{5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vec[nvec++] = '{5'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vec[nvec++] = '{5'd12, 32'h80000000, 32'h00000004, 32'h08000000, 1};
    vec[nvec++] = '{5'd14, 32'h12345678, 32'h00000001, 32'h00000000, 1};
    vec[nvec++] = '{5'd31, 32'h12345678, 32'h00000001, 32'h00000000, 1};
    vec[nvec++] = '{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vec[nvec++] = '{5'd17, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
    vec[nvec++] = '{5'd16, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 33};
    vec[nvec++] = '{5'd18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
    vec[nvec++] = '{5'd18, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 33};
    vec[nvec++] = '{5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vec[nvec++] = '{5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vec[nvec++] = '{5'd21, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 33};
    vec[nvec++] = '{5'd23, 32'h00000007, 32'h00000000, 32'h00000007, 33};
    vec[nvec++] = '{5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vec[nvec++] = '{5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vec[nvec++] = '{5'd20, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 33};
    vec[nvec++] = '{5'd22, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 33};
    vec[nvec++] = '{5'd21, 32'h0000000D, 32'h00000004, 32'h00000003, 33};

    repeat (3) @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset out", dout, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Single-cycle entries run back-to-back: each new request is driven in the result cycle.
    for (int i = 0; i < nvec; i++)
      run_op($sformatf("vec%0d", i), vec[i].c, vec[i].a, vec[i].b, vec[i].e, vec[i].lat);
    @(negedge clk);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    ctrl = 5'd2; data1 = 32'd2; data2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold out", dout, 32'd5);
      chk("hold out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("release out_valid", {31'b0, out_valid}, 32'd0);

    // Kill at cycle 10 of a divide, with a competing request that must not be taken.
    ctrl = 5'd20; data1 = 32'd100; data2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill pre busy", {31'b0, busy}, 32'd1);
    kill = 1'b1; ctrl = 5'd2; data1 = 32'd1; data2 = 32'd1; in_valid = 1'b1;
    #1;
    chk("kill in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0;
    #1;
    chk("post kill in_ready", {31'b0, in_ready}, 32'd1);
    chk("post kill busy", {31'b0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    chk("kill no result", cnt, 0);

    // Asynchronous reset during a multiply.
    ctrl = 5'd16; data1 = 32'd6; data2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre reset busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy}, 32'd0);
    chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("async reset out", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    chk("reset no result", cnt, 0);
    run_op("after reset mul", 5'd16, 32'd6, 32'd7, 32'd42, 33);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
